// File: rtl/miner_work_ctrl_if.sv
// Signal bundle between the miner work controller and its UART / miner-core neighbours.
// The slave modport is the controller's view; master is the surrounding system.
interface miner_work_ctrl_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [255:0] midstate;
  logic [95:0]  data2;
  logic         start_mining;
  logic         miner_busy;
  logic         got_ticket;
  logic [31:0]  golden_nonce;
  logic         ctrl_idle;
  logic         timeout_err;

  modport master (
    output rx_data, rx_valid, tx_ready, miner_busy, got_ticket, golden_nonce,
    input  tx_data, tx_valid, midstate, data2, start_mining, ctrl_idle, timeout_err
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready, miner_busy, got_ticket, golden_nonce,
    output tx_data, tx_valid, midstate, data2, start_mining, ctrl_idle, timeout_err
  );
endinterface

// File: rtl/miner_work_ctrl.sv
// Host-side driver for the SHA-256 miner core: 44-byte work packets in over UART RX,
// start/busy/ticket sequencing with the core, found nonce out as 4 bytes over UART TX.
//
// state       | meaning
// S_IDLE      | waiting for a complete packet (pending)
// S_START     | start_mining held high for START_LEN cycles
// S_WAIT_BUSY | waiting up to BUSY_TIMEOUT cycles for miner_busy to rise
// S_MINING    | core busy; new pending work aborts and restarts
// S_SETTLE    | SETTLE cycles after busy falls, then sample got_ticket
// S_SEND      | golden nonce returned MSB first over tx handshake
module miner_work_ctrl #(
  parameter int START_LEN    = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int SETTLE       = 4,
  parameter int RX_GAP       = 1000
) (
  input logic              clk,
  input logic              rst,
  miner_work_ctrl_if.slave bus
);

  localparam int TMR_MAX = (START_LEN > BUSY_TIMEOUT)
                         ? ((START_LEN > SETTLE) ? START_LEN : SETTLE)
                         : ((BUSY_TIMEOUT > SETTLE) ? BUSY_TIMEOUT : SETTLE);
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int GAP_W = $clog2(RX_GAP + 1);
  localparam logic [5:0] LAST_BYTE = 6'd43;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_MINING,
    S_SETTLE,
    S_SEND
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [351:0]       shadow;
  logic [5:0]         byte_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               pending;
  logic               pkt_done;
  logic [TMR_W-1:0]   tmr;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_ld;
  logic               tmr_zero;
  logic               load;
  logic               latch_nonce;
  logic               tx_adv;
  logic               to_fire;
  logic [31:0]        nonce;
  logic [1:0]         byte_idx;
  logic [255:0]       midstate_q;
  logic [95:0]        data2_q;
  logic               timeout_q;
  logic [7:0]         tx_byte;

  assign pkt_done = bus.rx_valid && (byte_cnt == LAST_BYTE);
  assign tmr_zero = (tmr == '0);

  // RX assembly runs regardless of FSM state; gap timer discards stale partial packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else if (bus.rx_valid) begin
      shadow[9'd351 - {byte_cnt, 3'b000} -: 8] <= bus.rx_data;
      byte_cnt <= pkt_done ? 6'd0 : byte_cnt + 6'd1;
      gap_cnt  <= GAP_W'(RX_GAP);
    end else if (byte_cnt != 6'd0) begin
      if (gap_cnt <= GAP_W'(1)) begin
        byte_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // A completing packet wins over a same-cycle load so the newer work is not dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (pkt_done) begin
      pending <= 1'b1;
    end else if (load) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    tmr_ld      = 1'b0;
    tmr_val     = '0;
    latch_nonce = 1'b0;
    tx_adv      = 1'b0;
    to_fire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          load      = 1'b1;
          tmr_ld    = 1'b1;
          tmr_val   = TMR_W'(START_LEN - 1);
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (tmr_zero) begin
          tmr_ld    = 1'b1;
          tmr_val   = TMR_W'(BUSY_TIMEOUT - 1);
          state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (bus.miner_busy) begin
          state_nxt = S_MINING;
        end else if (tmr_zero) begin
          to_fire   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_MINING: begin
        if (pending) begin
          load      = 1'b1;
          tmr_ld    = 1'b1;
          tmr_val   = TMR_W'(START_LEN - 1);
          state_nxt = S_START;
        end else if (!bus.miner_busy) begin
          tmr_ld    = 1'b1;
          tmr_val   = TMR_W'(SETTLE - 1);
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_zero) begin
          if (bus.got_ticket) begin
            latch_nonce = 1'b1;
            state_nxt   = S_SEND;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          tx_adv = 1'b1;
          if (byte_idx == 2'd3) begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (tmr_ld) begin
      tmr <= tmr_val;
    end else if (!tmr_zero) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      midstate_q <= '0;
      data2_q    <= '0;
      nonce      <= '0;
      byte_idx   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      if (load) begin
        midstate_q <= shadow[351:96];
        data2_q    <= shadow[95:0];
      end
      if (latch_nonce) begin
        nonce    <= bus.golden_nonce;
        byte_idx <= '0;
      end else if (tx_adv) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  always_comb begin
    tx_byte = '0;
    if (state == S_SEND) begin
      case (byte_idx)
        2'd0:    tx_byte = nonce[31:24];
        2'd1:    tx_byte = nonce[23:16];
        2'd2:    tx_byte = nonce[15:8];
        default: tx_byte = nonce[7:0];
      endcase
    end
  end

  assign bus.tx_data      = tx_byte;
  assign bus.tx_valid     = (state == S_SEND);
  assign bus.start_mining = (state == S_START);
  assign bus.midstate     = midstate_q;
  assign bus.data2        = data2_q;
  assign bus.ctrl_idle    = (state == S_IDLE) && !pending;
  assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_miner_work_ctrl.sv
// Directed bench for miner_work_ctrl with a small behavioural miner-core model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_miner_work_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  miner_work_ctrl_if bus ();

  miner_work_ctrl #(
    .START_LEN   (4),
    .BUSY_TIMEOUT(16),
    .SETTLE      (4),
    .RX_GAP      (1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int          core_mode;   // 0: ticket found, 1: exhausted, 2: never busy
  int          run_len;
  logic [31:0] ticket;
  int          core_cnt;
  logic        start_d;
  logic        give;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [351:0] pkt_img(input logic [7:0] base);
    logic [351:0] img;
    img = '0;
    for (int i = 0; i < 44; i++) img = {img[343:0], base + 8'(i)};
    return img;
  endfunction

  task automatic send_pkt(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_data  = base + 8'(i);
      bus.rx_valid = 1'b1;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic measure_start(output int len);
    int w;
    w = 0;
    len = 0;
    while (!bus.start_mining && w < 50) begin @(negedge clk); w++; end
    while (bus.start_mining && len < 50) begin @(negedge clk); len++; end
  endtask

  task automatic recv_nonce(input logic [31:0] exp, input int stall);
    int w;
    int unstable;
    logic [7:0] d0;
    for (int b = 0; b < 4; b++) begin
      w = 0;
      while (!bus.tx_valid && w < 1000) begin @(negedge clk); w++; end
      chk("tx_valid_up", 256'(bus.tx_valid), 256'(1));
      if (b == 0 && stall > 0) begin
        d0 = bus.tx_data;
        unstable = 0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          if (bus.tx_valid !== 1'b1 || bus.tx_data !== d0) unstable++;
        end
        chk("tx_stall_stable", 256'(unstable), 256'(0));
      end
      chk("tx_byte", 256'(bus.tx_data), 256'(exp[31-8*b -: 8]));
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
    end
    chk("tx_done", 256'(bus.tx_valid), 256'(0));
  endtask

  // Miner core model: busy follows the end of the start pulse, ticket lags busy by a cycle.
  initial begin
    bus.miner_busy   = 1'b0;
    bus.got_ticket   = 1'b0;
    bus.golden_nonce = '0;
    start_d  = 1'b0;
    give     = 1'b0;
    core_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || bus.start_mining) begin
        bus.miner_busy = 1'b0;
        bus.got_ticket = 1'b0;
        give = 1'b0;
      end else if (start_d && core_mode != 2) begin
        bus.miner_busy = 1'b1;
        core_cnt = run_len;
      end else if (bus.miner_busy) begin
        if (core_cnt <= 1) begin
          bus.miner_busy = 1'b0;
          give = (core_mode == 0);
        end else begin
          core_cnt--;
        end
      end else if (give) begin
        bus.golden_nonce = ticket;
        bus.got_ticket = 1'b1;
        give = 1'b0;
      end
      start_d = bus.start_mining;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int len;
    int cnt;
    int w;
    logic [351:0] img;

    rst = 1'b1;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    core_mode = 0;
    run_len   = 20;
    ticket    = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 256'(bus.tx_valid), 256'(0));
    chk("rst_tx_data", 256'(bus.tx_data), 256'(0));
    chk("rst_start", 256'(bus.start_mining), 256'(0));
    chk("rst_midstate", 256'(bus.midstate), 256'(0));
    chk("rst_data2", 256'(bus.data2), 256'(0));
    chk("rst_timeout", 256'(bus.timeout_err), 256'(0));
    chk("rst_idle", 256'(bus.ctrl_idle), 256'(1));
    rst = 1'b0;

    // 1: basic packet, ticket returned
    core_mode = 0; run_len = 20; ticket = 32'h8000_1234;
    send_pkt(8'h00, 44);
    chk("t1_start_pre", 256'(bus.start_mining), 256'(0));
    chk("t1_idle_pending", 256'(bus.ctrl_idle), 256'(0));
    @(negedge clk);
    chk("t1_start_rise", 256'(bus.start_mining), 256'(1));
    img = pkt_img(8'h00);
    chk("t1_midstate", 256'(bus.midstate), 256'(img[351:96]));
    chk("t1_data2", 256'(bus.data2), 256'(img[95:0]));
    chk("t1_ms_top", 256'(bus.midstate[255:248]), 256'(8'h00));
    chk("t1_d2_low", 256'(bus.data2[7:0]), 256'(8'h2B));
    measure_start(len);
    chk("t1_start_len", 256'(len), 256'(4));
    recv_nonce(32'h8000_1234, 0);
    chk("t1_idle_after", 256'(bus.ctrl_idle), 256'(1));

    // 2: nonce space exhausted, nothing sent
    core_mode = 1; run_len = 100;
    send_pkt(8'h30, 44);
    measure_start(len);
    chk("t2_start_len", 256'(len), 256'(4));
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.tx_valid || bus.timeout_err) cnt++;
    end
    chk("t2_no_tx", 256'(cnt), 256'(0));
    chk("t2_idle", 256'(bus.ctrl_idle), 256'(1));

    // 3: busy never rises
    core_mode = 2;
    send_pkt(8'h50, 44);
    measure_start(len);
    chk("t3_start_len", 256'(len), 256'(4));
    cnt = 0;
    while (!bus.timeout_err && cnt < 40) begin @(negedge clk); cnt++; end
    chk("t3_timeout_delay", 256'(cnt), 256'(16));
    chk("t3_idle", 256'(bus.ctrl_idle), 256'(1));
    @(negedge clk);
    chk("t3_pulse_width", 256'(bus.timeout_err), 256'(0));
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.timeout_err || bus.start_mining) cnt++;
    end
    chk("t3_single_pulse", 256'(cnt), 256'(0));

    // 4: new packet aborts mining; old ticket discarded
    core_mode = 0; run_len = 300; ticket = 32'h1111_1111;
    send_pkt(8'h10, 44);
    measure_start(len);
    repeat (5) @(negedge clk);
    send_pkt(8'h40, 44);
    img = pkt_img(8'h10);
    chk("t4_start_pre", 256'(bus.start_mining), 256'(0));
    chk("t4_ms_hold", 256'(bus.midstate), 256'(img[351:96]));
    ticket = 32'h2222_2222; run_len = 30;
    @(negedge clk);
    img = pkt_img(8'h40);
    chk("t4_restart", 256'(bus.start_mining), 256'(1));
    chk("t4_ms_new", 256'(bus.midstate), 256'(img[351:96]));
    chk("t4_d2_new", 256'(bus.data2), 256'(img[95:0]));
    measure_start(len);
    chk("t4_start_len", 256'(len), 256'(4));
    recv_nonce(32'h2222_2222, 0);

    // 5: TX stall with a new packet arriving during SEND
    core_mode = 0; run_len = 20; ticket = 32'hA5C3_0F96;
    send_pkt(8'h60, 44);
    w = 0;
    while (!bus.tx_valid && w < 1000) begin @(negedge clk); w++; end
    fork
      recv_nonce(32'hA5C3_0F96, 50);
      send_pkt(8'h90, 44);
    join
    chk("t5_start_pre", 256'(bus.start_mining), 256'(0));
    chk("t5_pending", 256'(bus.ctrl_idle), 256'(0));
    core_mode = 1; run_len = 10;
    @(negedge clk);
    img = pkt_img(8'h90);
    chk("t5_launch", 256'(bus.start_mining), 256'(1));
    chk("t5_ms", 256'(bus.midstate), 256'(img[351:96]));
    repeat (60) @(negedge clk);
    chk("t5_idle", 256'(bus.ctrl_idle), 256'(1));

    // 6: stale partial packet dropped, then reset during SEND
    send_pkt(8'hB0, 20);
    repeat (1005) @(negedge clk);
    core_mode = 0; run_len = 20; ticket = 32'h5A5A_C3C3;
    send_pkt(8'hC0, 44);
    @(negedge clk);
    img = pkt_img(8'hC0);
    chk("t6_start", 256'(bus.start_mining), 256'(1));
    chk("t6_ms", 256'(bus.midstate), 256'(img[351:96]));
    chk("t6_d2", 256'(bus.data2), 256'(img[95:0]));
    w = 0;
    while (!bus.tx_valid && w < 1000) begin @(negedge clk); w++; end
    chk("t6_tx_valid", 256'(bus.tx_valid), 256'(1));
    chk("t6_tx_b0", 256'(bus.tx_data), 256'(8'h5A));
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    chk("t6_tx_b1", 256'(bus.tx_data), 256'(8'h5A));
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tx_valid", 256'(bus.tx_valid), 256'(0));
    chk("t6_rst_tx_data", 256'(bus.tx_data), 256'(0));
    chk("t6_rst_start", 256'(bus.start_mining), 256'(0));
    chk("t6_rst_ms", 256'(bus.midstate), 256'(0));
    chk("t6_rst_d2", 256'(bus.data2), 256'(0));
    chk("t6_rst_idle", 256'(bus.ctrl_idle), 256'(1));
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tx_valid || bus.start_mining) cnt++;
    end
    chk("t6_quiet", 256'(cnt), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
